// File: rtl/rsrt_sum_writeback_seq_pkg.sv
// Shared definitions for the add-and-classify write-back sequencer:
// FSM state encoding and the class codes written to $rd.
package rsrt_sum_writeback_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WR_RS = 2'd2,
        S_WR_RD = 2'd3
    } state_e;

    localparam logic [1:0] CODE_ZERO = 2'd1;
    localparam logic [1:0] CODE_NEG  = 2'd2;
    localparam logic [1:0] CODE_POS  = 2'd3;

endpackage

// File: rtl/rsrt_sum_writeback_seq_if.sv
// Issue/write-port bundle between operand fetch, the sequencer and the register file.
// master = issuing side, slave = the sequencer.
interface rsrt_sum_writeback_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              busy;
    logic              reg_we;
    logic [ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic              done;
    logic              ovf;

    modport master (
        output start, rs_addr, rd_addr, rs_val, rt_val,
        input  busy, reg_we, reg_waddr, reg_wdata, done, ovf
    );

    modport slave (
        input  start, rs_addr, rd_addr, rs_val, rt_val,
        output busy, reg_we, reg_waddr, reg_wdata, done, ovf
    );
endinterface

// File: rtl/rsrt_sum_writeback_seq_sum_class_encode.sv
// Classifies a sum as a signed value: zero -> CODE_ZERO, negative -> CODE_NEG,
// positive -> CODE_POS. Purely combinational.
module sum_class_encode
    import rsrt_sum_writeback_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] sum,
    output logic [1:0]        code
);
    always_comb begin
        code = CODE_POS;
        if (sum == '0)
            code = CODE_ZERO;
        else if ($signed(sum) < $signed({DATA_W{1'b0}}))
            code = CODE_NEG;
    end
endmodule

// File: rtl/rsrt_sum_writeback_seq.sv
// Execute/write-back sequencer: $rs <= $rs + $rt, then $rd <= class of the sum,
// issued in that order on the single register-file write port over a fixed 4 cycles.
module rsrt_sum_writeback_seq
    import rsrt_sum_writeback_seq_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int SKIP_ZERO = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    rsrt_sum_writeback_seq_if.slave   bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rs_val_q, rs_val_d;
    logic [DATA_W-1:0] rt_val_q, rt_val_d;
    logic [1:0]        code_q, code_d;
    logic              ovf_q, ovf_d;

    logic              busy_q, busy_d;
    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              done_q, done_d;
    logic              ovf_out_q, ovf_out_d;

    logic [DATA_W-1:0] sum_calc;
    logic [1:0]        code_calc;
    logic              ovf_calc;

    assign sum_calc = rs_val_q + rt_val_q;
    assign ovf_calc = (rs_val_q[DATA_W-1] == rt_val_q[DATA_W-1]) &&
                      (sum_calc[DATA_W-1] != rs_val_q[DATA_W-1]);

    sum_class_encode #(.DATA_W(DATA_W)) u_encode (
        .sum  (sum_calc),
        .code (code_calc)
    );

    function automatic logic write_allowed(input logic [ADDR_W-1:0] addr);
        return (SKIP_ZERO == 0) || (addr != '0);
    endfunction

    // Outputs are registered: each state computes the values shown during the next one.
    // The reg_wdata register doubles as the sum register during WR_RS.
    always_comb begin
        state_d     = state_q;
        rs_addr_d   = rs_addr_q;
        rd_addr_d   = rd_addr_q;
        rs_val_d    = rs_val_q;
        rt_val_d    = rt_val_q;
        code_d      = code_q;
        ovf_d       = ovf_q;
        busy_d      = 1'b0;
        reg_we_d    = 1'b0;
        reg_waddr_d = '0;
        reg_wdata_d = '0;
        done_d      = 1'b0;
        ovf_out_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rs_addr_d = bus.rs_addr;
                    rd_addr_d = bus.rd_addr;
                    rs_val_d  = bus.rs_val;
                    rt_val_d  = bus.rt_val;
                    busy_d    = 1'b1;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                code_d      = code_calc;
                ovf_d       = ovf_calc;
                busy_d      = 1'b1;
                reg_we_d    = write_allowed(rs_addr_q);
                reg_waddr_d = rs_addr_q;
                reg_wdata_d = sum_calc;
                state_d     = S_WR_RS;
            end
            S_WR_RS: begin
                busy_d      = 1'b1;
                reg_we_d    = write_allowed(rd_addr_q);
                reg_waddr_d = rd_addr_q;
                reg_wdata_d = DATA_W'(code_q);
                done_d      = 1'b1;
                ovf_out_d   = ovf_q;
                state_d     = S_WR_RD;
            end
            S_WR_RD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rs_addr_q   <= '0;
            rd_addr_q   <= '0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            code_q      <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            done_q      <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_addr_q   <= rs_addr_d;
            rd_addr_q   <= rd_addr_d;
            rs_val_q    <= rs_val_d;
            rt_val_q    <= rt_val_d;
            code_q      <= code_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            done_q      <= done_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_waddr = reg_waddr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.done      = done_q;
    assign bus.ovf       = ovf_out_q;

endmodule

// File: tb/tb_rsrt_sum_writeback_seq.sv
// Directed bench for rsrt_sum_writeback_seq: expected writes are queued at issue
// time and popped/compared in the WR_RS and WR_RD cycles.
module tb_rsrt_sum_writeback_seq;
    import rsrt_sum_writeback_seq_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rsrt_sum_writeback_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rsrt_sum_writeback_seq #(.DATA_W(DW), .ADDR_W(AW), .SKIP_ZERO(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
        logic          ovf;
    } wr_t;

    wr_t           sb[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] rf [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: overflow from a wide signed add, class from the wrapped result.
    task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] s, output logic [1:0] c, output logic o);
        longint full;
        full = longint'($signed(a)) + longint'($signed(b));
        s = a + b;
        o = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        if (s == 0)     c = CODE_ZERO;
        else if (s[31]) c = CODE_NEG;
        else            c = CODE_POS;
    endtask

    task automatic pop_check(input string tag);
        wr_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_busy"},  bus.busy,      1'b1);
        chk({tag, "_we"},    bus.reg_we,    e.we);
        chk({tag, "_waddr"}, bus.reg_waddr, e.addr);
        chk({tag, "_wdata"}, bus.reg_wdata, e.data);
        chk({tag, "_done"},  bus.done,      e.done);
        chk({tag, "_ovf"},   bus.ovf,       e.ovf);
        if (bus.reg_we) rf[bus.reg_waddr] = bus.reg_wdata;
        $display("txn %s: we=%0b addr=%0d data=%08h done=%0b ovf=%0b",
                 tag, bus.reg_we, bus.reg_waddr, bus.reg_wdata, bus.done, bus.ovf);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge where it is back in IDLE
    // (or, with rst_mid, the negedge right after the reset cycle).
    task automatic run_op(input logic [AW-1:0] ra, input logic [AW-1:0] rd,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit repulse, input bit rst_mid);
        logic [DW-1:0] s;
        logic [1:0]    c;
        logic          o;
        model(a, b, s, c, o);
        sb.push_back('{we: (ra != 0), addr: ra, data: s, done: 1'b0, ovf: 1'b0});
        sb.push_back('{we: (rd != 0), addr: rd, data: DW'(c), done: 1'b1, ovf: o});
        bus.start   = 1'b1;
        bus.rs_addr = ra;
        bus.rd_addr = rd;
        bus.rs_val  = a;
        bus.rt_val  = b;
        @(negedge clk);
        chk("calc_busy", bus.busy, 1'b1);
        chk("calc_we",   bus.reg_we, 1'b0);
        chk("calc_done", bus.done, 1'b0);
        bus.start = repulse;
        if (repulse) begin
            bus.rs_addr = ra + 5'd1;
            bus.rd_addr = rd + 5'd1;
            bus.rs_val  = a ^ 32'h1234_5678;
            bus.rt_val  = b + 32'd99;
        end
        @(negedge clk);
        bus.start = 1'b0;
        pop_check("wr_rs");
        if (rst_mid) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("rst_busy",  bus.busy, 1'b0);
            chk("rst_we",    bus.reg_we, 1'b0);
            chk("rst_done",  bus.done, 1'b0);
            chk("rst_waddr", bus.reg_waddr, '0);
            chk("rst_wdata", bus.reg_wdata, '0);
            void'(sb.pop_front());
            return;
        end
        @(negedge clk);
        pop_check("wr_rd");
        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_we",   bus.reg_we, 1'b0);
        chk("idle_done", bus.done, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.rs_addr = '0;
        bus.rd_addr = '0;
        bus.rs_val  = '0;
        bus.rt_val  = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy",  bus.busy, 1'b0);
        chk("reset_we",    bus.reg_we, 1'b0);
        chk("reset_done",  bus.done, 1'b0);
        chk("reset_ovf",   bus.ovf, 1'b0);
        chk("reset_waddr", bus.reg_waddr, '0);
        chk("reset_wdata", bus.reg_wdata, '0);
        reset = 1'b0;
        @(negedge clk);

        run_op(5'd1, 5'd2, 32'd5, 32'hFFFF_FFFB, 1'b0, 1'b0);
        chk("r1_zero_sum", rf[1], 32'h0000_0000);
        chk("r2_code1",    rf[2], 32'd1);

        run_op(5'd4, 5'd5, 32'd3, 32'hFFFF_FFF6, 1'b0, 1'b0);
        chk("r4_sum", rf[4], 32'hFFFF_FFF9);
        chk("r5_neg", rf[5], 32'd2);

        run_op(5'd6, 5'd7, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        chk("r6_wrap", rf[6], 32'h8000_0000);
        chk("r7_neg",  rf[7], 32'd2);

        run_op(5'd9, 5'd9, 32'd7, 32'd8, 1'b0, 1'b0);
        chk("r9_final_code", rf[9], 32'd3);

        run_op(5'd0, 5'd3, 32'd10, 32'd20, 1'b0, 1'b0);
        chk("r0_untouched", rf[0], 32'd0);
        chk("r3_pos",       rf[3], 32'd3);

        run_op(5'd10, 5'd11, 32'd100, 32'd200, 1'b1, 1'b0);
        chk("r10_orig", rf[10], 32'd300);
        chk("r12_not_written", rf[12], 32'd0);

        run_op(5'd13, 5'd14, 32'd1, 32'd2, 1'b0, 1'b1);
        chk("r13_kept",    rf[13], 32'd3);
        chk("r14_dropped", rf[14], 32'd0);
        run_op(5'd15, 5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("r15_sum", rf[15], 32'hFFFF_FFFE);

        run_op(5'd17, 5'd18, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        chk("r17_wrap_zero", rf[17], 32'd0);
        chk("r18_zero",      rf[18], 32'd1);

        for (int i = 0; i < 4; i++) begin
            run_op(5'(20 + i), 5'(24 + i), $urandom, $urandom, 1'b0, 1'b0);
        end

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
